// File: rtl/uart_io_sched_pkg.sv
// Shared definitions for the UART I/O scheduler: register offsets,
// LSR bit positions and FSM state encoding.
package uart_io_sched_pkg;

  localparam logic [2:0] OFS_DATA = 3'd0;
  localparam logic [2:0] OFS_LSR  = 3'd1;
  localparam logic [2:0] OFS_DIVR = 3'd2;
  localparam logic [2:0] OFS_DIVT = 3'd3;

  localparam int LSR_RS = 0;
  localparam int LSR_TS = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_POLL    = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_RX_CLR  = 3'd3,
    ST_WR_DATA = 3'd4,
    ST_TX_HOLD = 3'd5
  } sched_state_t;

  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {24'h00_0000, b};
  endfunction

endpackage

// File: rtl/uart_sched_fifo.sv
// Byte FIFO used for both the TX and RX queues of the UART scheduler.
// Push while full is dropped unless a pop in the same cycle frees a slot.
module uart_sched_fifo
  import uart_io_sched_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify strobes against occupancy
  always_comb begin
    do_pop_s  = pop && (count_r != '0);
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Storage array, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/uart_io_sched.sv
// Polls a UART over a simple strobe/ack bus, moving bytes between it and
// two local FIFOs. Optional overrun tracking under UART_SCHED_OVERRUN_EN.
module uart_io_sched
  import uart_io_sched_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  input  logic [7:0]                  tx_wdata,
  input  logic                        tx_push,
  output logic                        tx_full,
  output logic [$clog2(TX_DEPTH):0]   tx_count,
  output logic [7:0]                  rx_rdata,
  input  logic                        rx_pop,
  output logic                        rx_empty,
  output logic                        irq,
`ifdef UART_SCHED_OVERRUN_EN
  output logic                        overrun,
  input  logic                        overrun_clr,
`endif
  output logic [2:0]                  U_ADD_O,
  output logic [31:0]                 U_DAT_O,
  input  logic [31:0]                 U_DAT_I,
  output logic                        U_STB_O,
  output logic                        U_WE_O,
  input  logic                        U_ACK_I
);

  sched_state_t                state_r;
  logic                        hold_r;
  logic                        ack_s;
  logic                        tx_pop_s;
  logic                        rx_push_s;
  logic                        tx_empty_s;
  logic                        rx_full_s;
  logic [7:0]                  tx_head_s;
  logic [$clog2(RX_DEPTH):0]   rx_count_s;
  logic                        unused_s;
`ifdef UART_SCHED_OVERRUN_EN
  logic                        discard_r;
  logic                        overrun_r;
`endif

  assign ack_s     = U_STB_O && U_ACK_I;
  assign tx_pop_s  = (state_r == ST_WR_DATA) && ack_s;
`ifdef UART_SCHED_OVERRUN_EN
  assign rx_push_s = (state_r == ST_RD_DATA) && ack_s && !discard_r;
`else
  assign rx_push_s = (state_r == ST_RD_DATA) && ack_s;
`endif
  assign tx_full   = (tx_count == ($clog2(TX_DEPTH)+1)'(TX_DEPTH));
  assign rx_full_s = (rx_count_s == ($clog2(RX_DEPTH)+1)'(RX_DEPTH));
  assign irq       = !rx_empty;
  assign unused_s  = ^U_DAT_I[31:8];

  uart_sched_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (tx_push),
    .wdata (tx_wdata),
    .pop   (tx_pop_s),
    .rdata (tx_head_s),
    .empty (tx_empty_s),
    .count (tx_count)
  );

  uart_sched_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (CLK_I),
    .rst   (RST_I),
    .push  (rx_push_s),
    .wdata (U_DAT_I[7:0]),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .count (rx_count_s)
  );

  // Scheduler FSM; each bus state enters with strobe low, raises it, and drops it on ack
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_r   <= ST_IDLE;
      hold_r    <= 1'b0;
      U_STB_O   <= 1'b0;
      U_WE_O    <= 1'b0;
      U_ADD_O   <= 3'd0;
      U_DAT_O   <= 32'h0000_0000;
`ifdef UART_SCHED_OVERRUN_EN
      discard_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: state_r <= ST_POLL;
        ST_POLL: begin
          if (!U_STB_O) begin
            U_STB_O <= 1'b1;
            U_WE_O  <= 1'b0;
            U_ADD_O <= OFS_LSR;
          end else if (U_ACK_I) begin
            U_STB_O <= 1'b0;
            if (U_DAT_I[LSR_RS] && !rx_full_s) begin
              state_r <= ST_RD_DATA;
`ifdef UART_SCHED_OVERRUN_EN
              discard_r <= 1'b0;
            end else if (U_DAT_I[LSR_RS]) begin
              state_r   <= ST_RD_DATA;
              discard_r <= 1'b1;
`endif
            end else if (U_DAT_I[LSR_TS] && !tx_empty_s) begin
              state_r <= ST_WR_DATA;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_RD_DATA: begin
          if (!U_STB_O) begin
            U_STB_O <= 1'b1;
            U_WE_O  <= 1'b0;
            U_ADD_O <= OFS_DATA;
          end else if (U_ACK_I) begin
            U_STB_O <= 1'b0;
            state_r <= ST_RX_CLR;
          end
        end
        ST_RX_CLR: begin
          if (!U_STB_O) begin
            U_STB_O <= 1'b1;
            U_WE_O  <= 1'b1;
            U_ADD_O <= OFS_LSR;
            U_DAT_O <= 32'h0000_0000;
          end else if (U_ACK_I) begin
            U_STB_O <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_WR_DATA: begin
          if (!U_STB_O) begin
            U_STB_O <= 1'b1;
            U_WE_O  <= 1'b1;
            U_ADD_O <= OFS_DATA;
            U_DAT_O <= byte_word(tx_head_s);
          end else if (U_ACK_I) begin
            U_STB_O <= 1'b0;
            hold_r  <= 1'b0;
            state_r <= ST_TX_HOLD;
          end
        end
        ST_TX_HOLD: begin
          // Two quiet cycles let the UART drop its stale transmit-space flag
          if (hold_r) state_r <= ST_IDLE;
          hold_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          U_STB_O <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_SCHED_OVERRUN_EN
  // Sticky overrun flag; a discard in the same cycle as a clear keeps it set
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      overrun_r <= 1'b0;
    end else if ((state_r == ST_RD_DATA) && ack_s && discard_r) begin
      overrun_r <= 1'b1;
    end else if (overrun_clr) begin
      overrun_r <= 1'b0;
    end else begin
      overrun_r <= overrun_r;
    end
  end

  assign overrun = overrun_r;
`endif

endmodule
